// File: rtl/instr_fetch_q.sv
// instr_fetch_q: prefetching instruction fetch stage.
// A DEPTH-entry queue decouples instruction memory from decode, with
// credit-based request flow control and redirect flushing of stale responses.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
module instr_fetch_q #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] PC_INC   = XLEN'(4)
) (
    input  logic            clk_i,
    input  logic            resetn_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [XLEN-1:0] imem_rsp_data_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_addr_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_stall_o,
    output logic [31:0]     perf_flush_o
`endif
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned SW = CW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    state_e          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];

    logic            req_valid_c;
    logic            req_fire_c;
    logic            push_c;
    logic            pop_c;

    // Next-state: credit check, request/response accounting, queue and redirect.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        count_d    = count_q;
        drop_d     = drop_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        mem_d      = mem_q;
        push_c     = 1'b0;
        pop_c      = 1'b0;

        req_valid_c = (state_q == RUN) &&
                      ((SW'(count_q) + SW'(outst_q)) < SW'(DEPTH));
        req_fire_c  = req_valid_c && imem_req_ready_i;

        if (state_q == IDLE) begin
            state_d = RUN;
        end

        if (req_fire_c) begin
            fetch_pc_d = fetch_pc_q + PC_INC;
        end

        // Every response retires one outstanding request, stale or not.
        outst_d = outst_q + CW'(req_fire_c) - CW'(imem_rsp_valid_i);

        if (redirect_valid_i) begin
            // Flush everything; all requests still in flight become stale.
            fetch_pc_d = redirect_addr_i;
            rsp_pc_d   = redirect_addr_i;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            drop_d     = outst_d;
        end else begin
            if (imem_rsp_valid_i) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CW'(1);
                end else begin
                    push_c = 1'b1;
                end
            end
            pop_c = (count_q != '0) && instr_ready_i;
            if (push_c) begin
                mem_d[wr_ptr_q] = '{pc: rsp_pc_q, instr: imem_rsp_data_i};
                wr_ptr_d        = wr_ptr_q + PW'(1);
                rsp_pc_d        = rsp_pc_q + PC_INC;
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push_c) - CW'(pop_c);
        end
    end

    // State and queue registers.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            mem_q      <= mem_d;
        end
    end

    assign imem_req_valid_o = req_valid_c;
    assign imem_addr_o      = fetch_pc_q;
    assign instr_valid_o    = (count_q != '0);
    assign instr_o          = mem_q[rd_ptr_q].instr;
    assign pc_o             = mem_q[rd_ptr_q].pc;

    // Credits make an overflowing push impossible; flag it if it ever happens.
    assert property (@(posedge clk_i) disable iff (!resetn_i)
                     !(push_c && (count_q == CW'(DEPTH))));

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    // Saturating counters: stalled request cycles and redirects.
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if ((state_q == RUN) && !req_valid_c && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
        if (redirect_valid_i && (perf_flush_q != '1)) begin
            perf_flush_d = perf_flush_q + 32'd1;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_o = perf_stall_q;
    assign perf_flush_o = perf_flush_q;
`endif

endmodule

// File: tb/tb_instr_fetch_q.sv
// Testbench for instr_fetch_q: in-order memory model with random latency,
// random handshakes and redirects, checked against a stream-level model.
`timescale 1ns/1ps
module tb_instr_fetch_q;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;

    logic            clk_i = 1'b0;
    logic            resetn_i;
    logic            imem_req_valid_o;
    logic            imem_req_ready_i;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_rsp_valid_i;
    logic [XLEN-1:0] imem_rsp_data_i;
    logic            redirect_valid_i;
    logic [XLEN-1:0] redirect_addr_i;
    logic            instr_valid_o;
    logic            instr_ready_i;
    logic [XLEN-1:0] instr_o;
    logic [XLEN-1:0] pc_o;
`ifdef IF_PERF_CNT_EN
    logic [31:0]     perf_stall_o;
    logic [31:0]     perf_flush_o;
`endif

    always #5 clk_i = ~clk_i;

    instr_fetch_q #(
        .XLEN    (XLEN),
        .DEPTH   (DEPTH),
        .RESET_PC(32'h0),
        .PC_INC  (32'd4)
    ) dut (
        .clk_i           (clk_i),
        .resetn_i        (resetn_i),
        .imem_req_valid_o(imem_req_valid_o),
        .imem_req_ready_i(imem_req_ready_i),
        .imem_addr_o     (imem_addr_o),
        .imem_rsp_valid_i(imem_rsp_valid_i),
        .imem_rsp_data_i (imem_rsp_data_i),
        .redirect_valid_i(redirect_valid_i),
        .redirect_addr_i (redirect_addr_i),
        .instr_valid_o   (instr_valid_o),
        .instr_ready_i   (instr_ready_i),
        .instr_o         (instr_o),
        .pc_o            (pc_o)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_stall_o    (perf_stall_o),
        .perf_flush_o    (perf_flush_o)
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int unsigned lat_min = 1;
    int unsigned lat_max = 1;
    int unsigned req_pct = 100;
    int unsigned ins_pct = 100;

    // Memory model: accepted addresses with the cycle their response is due.
    logic [31:0] mq_addr[$];
    int          mq_due[$];

    // Stream model: next request address and next delivered PC.
    logic [31:0] exp_fetch;
    logic [31:0] exp_pc;

    logic        redir_req  = 1'b0;
    logic [31:0] redir_addr = '0;

    // Per-cycle observations (sampled at negedge) and model values for them.
    logic        o_rv, o_iv, o_fire, o_pop, o_redir;
    logic [31:0] o_addr, o_pc, o_instr, o_exp_fetch, o_exp_pc;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic assert_reset();
        resetn_i         = 1'b0;
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;
        redirect_valid_i = 1'b0;
        redirect_addr_i  = '0;
        instr_ready_i    = 1'b0;
        redir_req        = 1'b0;
        mq_addr.delete();
        mq_due.delete();
    endtask

    task automatic release_reset();
        @(negedge clk_i);
        resetn_i  = 1'b1;
        cyc       = 0;
        exp_fetch = 32'h0;
        exp_pc    = 32'h0;
    endtask

    // One clock cycle: observe, drive handshakes and memory, advance the model.
    task automatic cycle();
        int due;
        logic [31:0] a;
        @(negedge clk_i);
        cyc++;
        o_rv        = imem_req_valid_o;
        o_addr      = imem_addr_o;
        o_iv        = instr_valid_o;
        o_pc        = pc_o;
        o_instr     = instr_o;
        o_exp_fetch = exp_fetch;
        o_exp_pc    = exp_pc;
        o_redir     = redir_req;

        imem_req_ready_i = ($urandom_range(99) < req_pct);
        instr_ready_i    = ($urandom_range(99) < ins_pct);
        redirect_valid_i = redir_req;
        redirect_addr_i  = redir_addr;
        redir_req        = 1'b0;

        if (mq_addr.size() != 0 && mq_due[0] <= cyc) begin
            a                = mq_addr.pop_front();
            void'(mq_due.pop_front());
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = memf(a);
        end else begin
            imem_rsp_valid_i = 1'b0;
            imem_rsp_data_i  = $urandom;
        end

        o_fire = o_rv && imem_req_ready_i;
        o_pop  = o_iv && instr_ready_i;
        if (o_fire) begin
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (mq_due.size() != 0 && due <= mq_due[$]) due = mq_due[$] + 1;
            mq_addr.push_back(o_addr);
            mq_due.push_back(due);
        end

        if (o_redir) begin
            exp_fetch = redir_addr;
            exp_pc    = redir_addr;
        end else begin
            if (o_fire) exp_fetch = exp_fetch + 32'd4;
            if (o_pop)  exp_pc    = exp_pc + 32'd4;
        end
    endtask

    task automatic test_reset();
        lat_min = 1; lat_max = 1; req_pct = 100; ins_pct = 100;
        assert_reset();
        repeat (2) @(negedge clk_i);
        #1;
        total++;
        if ({imem_req_valid_o, imem_addr_o, instr_valid_o, instr_o, pc_o} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got rv=%0b addr=%h iv=%0b instr=%h pc=%h want all 0",
                     imem_req_valid_o, imem_addr_o, instr_valid_o, instr_o, pc_o);
        end
`ifdef IF_PERF_CNT_EN
        total++;
        if ({perf_stall_o, perf_flush_o} !== 64'h0) begin
            bad++;
            $display("FAIL reset_perf got stall=%0d flush=%0d want 0 0", perf_stall_o, perf_flush_o);
        end
`endif
        release_reset();
    endtask

    task automatic test_stream();
        for (int i = 0; i < 16; i++) begin
            cycle();
            total++;
            if (o_rv !== 1'b1 || o_addr !== 32'(4 * (cyc - 1))) begin
                bad++;
                $display("FAIL stream_req cyc=%0d got rv=%0b addr=%h want rv=1 addr=%h",
                         cyc, o_rv, o_addr, 32'(4 * (cyc - 1)));
            end
            total++;
            if (o_iv !== (cyc >= 3)) begin
                bad++;
                $display("FAIL stream_valid cyc=%0d got %0b want %0b", cyc, o_iv, cyc >= 3);
            end
            if (cyc >= 3) begin
                total++;
                if (o_pc !== 32'(4 * (cyc - 3)) || o_instr !== memf(32'(4 * (cyc - 3)))) begin
                    bad++;
                    $display("FAIL stream_data cyc=%0d got pc=%h instr=%h want pc=%h instr=%h",
                             cyc, o_pc, o_instr, 32'(4 * (cyc - 3)), memf(32'(4 * (cyc - 3))));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int nfire = 0;
        int ndel  = 0;
        logic resumed = 1'b0;
        assert_reset();
        lat_min = 1; lat_max = 1; req_pct = 100; ins_pct = 0;
        release_reset();
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (o_fire) nfire++;
            total++;
            if (o_rv !== (cyc <= 4)) begin
                bad++;
                $display("FAIL bp_credit cyc=%0d got rv=%0b want %0b", cyc, o_rv, cyc <= 4);
            end
        end
        total++;
        if (nfire !== 4) begin
            bad++;
            $display("FAIL bp_accepts got %0d want 4", nfire);
        end
        total++;
        if (o_iv !== 1'b1 || o_pc !== 32'h0) begin
            bad++;
            $display("FAIL bp_head got iv=%0b pc=%h want iv=1 pc=0", o_iv, o_pc);
        end
        ins_pct = 100;
        for (int i = 0; i < 16; i++) begin
            cycle();
            if (o_pop) begin
                total++;
                if (o_pc !== 32'(4 * ndel) || o_instr !== memf(32'(4 * ndel))) begin
                    bad++;
                    $display("FAIL bp_drain got pc=%h instr=%h want pc=%h", o_pc, o_instr, 32'(4 * ndel));
                end
                ndel++;
            end
            if (o_fire && !resumed) begin
                resumed = 1'b1;
                total++;
                if (o_addr !== 32'h10) begin
                    bad++;
                    $display("FAIL bp_resume got addr=%h want 00000010", o_addr);
                end
            end
        end
        total++;
        if (!resumed || ndel < 8) begin
            bad++;
            $display("FAIL bp_progress got resumed=%0b delivered=%0d want 1 and >=8", resumed, ndel);
        end
    endtask

    task automatic test_redirect_inflight();
        logic found = 1'b0;
        assert_reset();
        lat_min = 3; lat_max = 3; req_pct = 100; ins_pct = 100;
        release_reset();
        cycle();
        cycle();
        redir_req  = 1'b1;
        redir_addr = 32'h100;
        cycle();
        total++;
        if (o_fire !== 1'b1) begin
            bad++;
            $display("FAIL inflight_setup got accept=%0b want 1", o_fire);
        end
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (cyc == 4) begin
                total++;
                if (o_rv !== 1'b1 || o_addr !== 32'h100) begin
                    bad++;
                    $display("FAIL inflight_req got rv=%0b addr=%h want rv=1 addr=00000100", o_rv, o_addr);
                end
            end
            if (o_iv) begin
                found = 1'b1;
                total++;
                if (cyc !== 8 || o_pc !== 32'h100 || o_instr !== memf(32'h100)) begin
                    bad++;
                    $display("FAIL inflight_first got cyc=%0d pc=%h instr=%h want cyc=8 pc=00000100 instr=%h",
                             cyc, o_pc, o_instr, memf(32'h100));
                end
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL inflight_timeout got no instruction want pc=00000100");
        end
    endtask

    task automatic test_redirect_collide();
        assert_reset();
        lat_min = 1; lat_max = 1; req_pct = 100; ins_pct = 100;
        release_reset();
        repeat (6) cycle();
        redir_req  = 1'b1;
        redir_addr = 32'h400;
        cycle();
        total++;
        if ((o_pop && imem_rsp_valid_i) !== 1'b1) begin
            bad++;
            $display("FAIL collide_setup got pop=%0b rsp=%0b want 1 1", o_pop, imem_rsp_valid_i);
        end
        for (int k = 1; k <= 10; k++) begin
            cycle();
            if (k <= 2) begin
                total++;
                if (o_iv !== 1'b0) begin
                    bad++;
                    $display("FAIL collide_flush k=%0d got iv=%0b pc=%h want iv=0", k, o_iv, o_pc);
                end
            end
            if (k == 3) begin
                total++;
                if (o_iv !== 1'b1 || o_pc !== 32'h400) begin
                    bad++;
                    $display("FAIL collide_first got iv=%0b pc=%h want iv=1 pc=00000400", o_iv, o_pc);
                end
            end
            if (o_iv) begin
                total++;
                if (o_pc !== o_exp_pc || o_instr !== memf(o_exp_pc)) begin
                    bad++;
                    $display("FAIL collide_stream got pc=%h instr=%h want pc=%h", o_pc, o_instr, o_exp_pc);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic first = 1'b1;
        int   ndel  = 0;
        assert_reset();
        lat_min = 2; lat_max = 2; req_pct = 100; ins_pct = 100;
        release_reset();
        repeat (4) cycle();
        redir_req  = 1'b1;
        redir_addr = 32'h200;
        cycle();
        redir_req  = 1'b1;
        redir_addr = 32'h300;
        cycle();
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (o_iv) begin
                if (first) begin
                    first = 1'b0;
                    total++;
                    if (o_pc !== 32'h300) begin
                        bad++;
                        $display("FAIL b2b_first got pc=%h want 00000300", o_pc);
                    end
                end
                total++;
                if (o_pc !== o_exp_pc || o_instr !== memf(o_exp_pc)) begin
                    bad++;
                    $display("FAIL b2b_stream got pc=%h instr=%h want pc=%h", o_pc, o_instr, o_exp_pc);
                end
                if (o_pop) ndel++;
            end
        end
        total++;
        if (ndel < 10) begin
            bad++;
            $display("FAIL b2b_progress got delivered=%0d want >=10", ndel);
        end
`ifdef IF_PERF_CNT_EN
        total++;
        if (perf_flush_o !== 32'd2) begin
            bad++;
            $display("FAIL b2b_perf_flush got %0d want 2", perf_flush_o);
        end
`endif
    endtask

    task automatic test_reset_mid();
        assert_reset();
        lat_min = 1; lat_max = 1; req_pct = 100; ins_pct = 100;
        release_reset();
        repeat (8) cycle();
        #2;
        assert_reset();
        #1;
        total++;
        if ({imem_req_valid_o, imem_addr_o, instr_valid_o, instr_o, pc_o} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs got rv=%0b addr=%h iv=%0b instr=%h pc=%h want all 0",
                     imem_req_valid_o, imem_addr_o, instr_valid_o, instr_o, pc_o);
        end
`ifdef IF_PERF_CNT_EN
        total++;
        if ({perf_stall_o, perf_flush_o} !== 64'h0) begin
            bad++;
            $display("FAIL midreset_perf got stall=%0d flush=%0d want 0 0", perf_stall_o, perf_flush_o);
        end
`endif
        release_reset();
        cycle();
        total++;
        if (o_rv !== 1'b1 || o_addr !== 32'h0) begin
            bad++;
            $display("FAIL midreset_restart got rv=%0b addr=%h want rv=1 addr=0", o_rv, o_addr);
        end
        cycle();
        cycle();
        total++;
        if (o_iv !== 1'b1 || o_pc !== 32'h0 || o_instr !== memf(32'h0)) begin
            bad++;
            $display("FAIL midreset_first got iv=%0b pc=%h instr=%h want iv=1 pc=0", o_iv, o_pc, o_instr);
        end
    endtask

    task automatic test_random();
        int ndel = 0;
        assert_reset();
        lat_min = 1; lat_max = 3; req_pct = 70; ins_pct = 60;
        release_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) < 4) begin
                redir_req  = 1'b1;
                redir_addr = $urandom & 32'hFFFF_FFFC;
            end
            cycle();
            if (o_rv) begin
                total++;
                if (o_addr !== o_exp_fetch) begin
                    bad++;
                    $display("FAIL rand_addr cyc=%0d got %h want %h", cyc, o_addr, o_exp_fetch);
                end
            end
            if (o_iv) begin
                total++;
                if (o_pc !== o_exp_pc || o_instr !== memf(o_exp_pc)) begin
                    bad++;
                    $display("FAIL rand_data cyc=%0d got pc=%h instr=%h want pc=%h instr=%h",
                             cyc, o_pc, o_instr, o_exp_pc, memf(o_exp_pc));
                end
                if (o_pop && !o_redir) ndel++;
            end
        end
        total++;
        if (ndel < 100) begin
            bad++;
            $display("FAIL rand_progress got delivered=%0d want >=100", ndel);
        end
    endtask

    initial begin
        assert_reset();
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_collide();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
